// File: rtl/avalon_mm_arbiter_pkg.sv
// Shared types for the two-requester Avalon-MM arbiter.
package avalon_mm_arbiter_pkg;

  typedef logic [31:0] uint32_t;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } requester_t;

endpackage

// File: rtl/avalon_mm_arbiter_owner_fifo.sv
// Owner-id FIFO: records which requester issued each outstanding read so
// responses can be routed back in order. A pop frees a slot for a same-cycle push.
module avalon_mm_arbiter_owner_fifo
  import avalon_mm_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  requester_t    push_data_i,
  input  logic          pop_i,
  output requester_t    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  requester_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= REQ_INSTR;
      end
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter merging an instruction (read-only) and a data requester
// onto one Avalon-MM host port, with in-order routing of pipelined read data.
module avalon_mm_arbiter
  import avalon_mm_arbiter_pkg::*;
#(
  parameter  int MAX_PENDING = 4,
  localparam int CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  uint32_t       i_address,
  input  logic [3:0]    i_byteenable,
  input  logic          i_read,
  output logic          i_waitrequest,
  output uint32_t       i_readdata,
  output logic          i_readdatavalid,
  input  uint32_t       d_address,
  input  logic [3:0]    d_byteenable,
  input  logic          d_read,
  input  logic          d_write,
  input  uint32_t       d_writedata,
  output logic          d_waitrequest,
  output uint32_t       d_readdata,
  output logic          d_readdatavalid,
  output uint32_t       h_address,
  output logic [3:0]    h_byteenable,
  output logic          h_read,
  output logic          h_write,
  output uint32_t       h_writedata,
  input  logic          h_waitrequest,
  input  uint32_t       h_readdata,
  input  logic          h_readdatavalid,
  output logic [CW-1:0] pending_count,
  output logic          err_unexpected_rdv
);

  logic       locked_q, locked_d;
  requester_t owner_q, owner_d;
  requester_t last_q, last_d;
  logic       err_q, err_d;

  requester_t win_s;
  requester_t head_s;
  logic       i_req_s, d_req_s, grant_s;
  logic       cmd_rd_s, cmd_wr_s, blocked_s;
  logic       issue_s, accept_s, push_s, pop_s;
  logic       fifo_full_s, fifo_empty_s;

  assign i_req_s = i_read;
  assign d_req_s = d_read || d_write;
  assign grant_s = rst && (locked_q || i_req_s || d_req_s);

  // Winner: frozen owner while locked, otherwise round-robin against last grant.
  always_comb begin
    win_s = REQ_DATA;
    if (locked_q) begin
      win_s = owner_q;
    end else if (i_req_s && d_req_s) begin
      win_s = (last_q == REQ_DATA) ? REQ_INSTR : REQ_DATA;
    end else if (i_req_s) begin
      win_s = REQ_INSTR;
    end else begin
      win_s = REQ_DATA;
    end
  end

  // Host command mux; all-zero when nobody is granted or reset is asserted.
  always_comb begin
    cmd_rd_s     = 1'b0;
    cmd_wr_s     = 1'b0;
    h_address    = 32'h0000_0000;
    h_byteenable = 4'h0;
    h_writedata  = 32'h0000_0000;
    if (grant_s) begin
      if (win_s == REQ_INSTR) begin
        cmd_rd_s     = i_read;
        h_address    = i_address;
        h_byteenable = i_byteenable;
      end else begin
        cmd_rd_s     = d_read;
        cmd_wr_s     = d_write;
        h_address    = d_address;
        h_byteenable = d_byteenable;
        h_writedata  = d_writedata;
      end
    end else begin
      cmd_rd_s = 1'b0;
    end
  end

  // A read is held off only when the FIFO stays full this cycle.
  assign pop_s     = h_readdatavalid && !fifo_empty_s;
  assign blocked_s = cmd_rd_s && fifo_full_s && !pop_s;
  assign h_read    = cmd_rd_s && !blocked_s;
  assign h_write   = cmd_wr_s;
  assign issue_s   = h_read || h_write;
  assign accept_s  = issue_s && !h_waitrequest;
  assign push_s    = h_read && !h_waitrequest;

  assign i_waitrequest   = !(grant_s && (win_s == REQ_INSTR)) || h_waitrequest || blocked_s;
  assign d_waitrequest   = !(grant_s && (win_s == REQ_DATA)) || h_waitrequest || blocked_s;
  assign i_readdata      = h_readdata;
  assign d_readdata      = h_readdata;
  assign i_readdatavalid = pop_s && (head_s == REQ_INSTR);
  assign d_readdatavalid = pop_s && (head_s == REQ_DATA);
  assign err_unexpected_rdv = err_q;

  // Grant lock and round-robin history; unexpected-response flag is sticky.
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    last_d   = last_q;
    err_d    = err_q || (h_readdatavalid && fifo_empty_s);
    if (issue_s && h_waitrequest) begin
      locked_d = 1'b1;
      owner_d  = win_s;
    end else if (accept_s) begin
      locked_d = 1'b0;
      last_d   = win_s;
    end else begin
      locked_d = locked_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_q <= 1'b0;
      owner_q  <= REQ_INSTR;
      last_q   <= REQ_DATA;
      err_q    <= 1'b0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  avalon_mm_arbiter_owner_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_owner_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push_s),
    .push_data_i (win_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (pending_count)
  );

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a queue-based model.
module tb_avalon_mm_arbiter;
  import avalon_mm_arbiter_pkg::*;

  localparam int MAXP = 4;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int RI   = 0;
  localparam int RD   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] i_address, d_address, d_writedata, h_readdata;
  logic [3:0]  i_byteenable, d_byteenable;
  logic        i_read, d_read, d_write, h_waitrequest, h_readdatavalid;
  logic        i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
  logic [31:0] i_readdata, d_readdata, h_address, h_writedata;
  logic [3:0]  h_byteenable;
  logic        h_read, h_write, err_unexpected_rdv;
  logic [CW-1:0] pending_count;

  avalon_mm_arbiter #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_byteenable(i_byteenable), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_byteenable(d_byteenable), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .h_address(h_address), .h_byteenable(h_byteenable), .h_read(h_read), .h_write(h_write),
    .h_writedata(h_writedata), .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
    .h_readdatavalid(h_readdatavalid),
    .pending_count(pending_count), .err_unexpected_rdv(err_unexpected_rdv)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: who won last, whether a stalled command is held, and the
  // order of outstanding read owners.
  bit m_locked;
  int m_owner;
  int m_last;
  bit m_err;
  int m_q[$];

  // Expected outputs for the current cycle.
  int   e_win;
  logic e_hr, e_hw, e_iw, e_dw, e_irdv, e_drdv;
  logic [31:0] e_ha, e_hwd;
  logic [3:0]  e_hbe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit ireq, dreq, g, rd, wr, rsp, blk;
    if (!rst) begin
      m_locked = 1'b0; m_owner = RI; m_last = RD; m_err = 1'b0; m_q.delete();
      e_hr = 1'b0; e_hw = 1'b0; e_ha = 32'h0; e_hbe = 4'h0; e_hwd = 32'h0;
      e_iw = 1'b1; e_dw = 1'b1; e_irdv = 1'b0; e_drdv = 1'b0; e_win = RD;
      return;
    end
    ireq = i_read;
    dreq = d_read || d_write;
    if (m_locked)          e_win = m_owner;
    else if (ireq && dreq) e_win = (m_last == RI) ? RD : RI;
    else if (ireq)         e_win = RI;
    else                   e_win = RD;
    g   = m_locked || ireq || dreq;
    rd  = g && ((e_win == RI) ? i_read : d_read);
    wr  = g && (e_win == RD) && d_write;
    rsp = h_readdatavalid && (m_q.size() > 0);
    blk = rd && (m_q.size() == MAXP) && !rsp;
    e_hr  = rd && !blk;
    e_hw  = wr;
    e_ha  = !g ? 32'h0 : (e_win == RI) ? i_address : d_address;
    e_hbe = !g ? 4'h0  : (e_win == RI) ? i_byteenable : d_byteenable;
    e_hwd = (g && e_win == RD) ? d_writedata : 32'h0;
    e_iw  = !(g && e_win == RI) || h_waitrequest || blk;
    e_dw  = !(g && e_win == RD) || h_waitrequest || blk;
    e_irdv = rsp && (m_q[0] == RI);
    e_drdv = rsp && (m_q[0] == RD);
  endtask

  task automatic model_update();
    if (!rst) return;
    if (h_readdatavalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (e_hr && !h_waitrequest) m_q.push_back(e_win);
    if ((e_hr || e_hw) && h_waitrequest) begin
      m_locked = 1'b1; m_owner = e_win;
    end else if ((e_hr || e_hw) && !h_waitrequest) begin
      m_locked = 1'b0; m_last = e_win;
    end
  endtask

  // Compare every output against the model, away from the clock edge.
  task automatic settle();
    #2;
    model_eval();
    chk("h_read", 32'(h_read), 32'(e_hr));
    chk("h_write", 32'(h_write), 32'(e_hw));
    chk("h_address", h_address, e_ha);
    chk("h_byteenable", 32'(h_byteenable), 32'(e_hbe));
    chk("h_writedata", h_writedata, e_hwd);
    chk("i_waitrequest", 32'(i_waitrequest), 32'(e_iw));
    chk("d_waitrequest", 32'(d_waitrequest), 32'(e_dw));
    chk("i_readdatavalid", 32'(i_readdatavalid), 32'(e_irdv));
    chk("d_readdatavalid", 32'(d_readdatavalid), 32'(e_drdv));
    chk("i_readdata", i_readdata, h_readdata);
    chk("d_readdata", d_readdata, h_readdata);
    chk("pending_count", 32'(pending_count), 32'(m_q.size()));
    chk("err_unexpected_rdv", 32'(err_unexpected_rdv), 32'(m_err));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    i_read = 1'b0; i_address = 32'h0; i_byteenable = 4'h0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'h0; d_byteenable = 4'h0; d_writedata = 32'h0;
    h_waitrequest = 1'b0; h_readdatavalid = 1'b0; h_readdata = 32'h0;
  endtask

  initial begin
    bit i_hold, d_hold;
    idle();
    @(negedge clk);
    // Reset state
    rst = 1'b0; i_read = 1'b1; settle();
    chk("rst_iw", 32'(i_waitrequest), 32'd1);
    chk("rst_dw", 32'(d_waitrequest), 32'd1);
    chk("rst_hread", 32'(h_read), 32'd0);
    chk("rst_count", 32'(pending_count), 32'd0);
    advance();
    rst = 1'b1; idle(); settle(); advance();

    // Contention: instruction wins first tie, then strict alternation
    for (int k = 0; k < 4; k++) begin
      i_read = 1'b1; i_address = 32'h10; i_byteenable = 4'hF;
      d_write = 1'b1; d_address = 32'h20; d_byteenable = 4'h3; d_writedata = 32'h1234;
      settle();
      chk("cont_hread", 32'(h_read), 32'((k % 2) == 0));
      chk("cont_hwrite", 32'(h_write), 32'((k % 2) == 1));
      chk("cont_iw", 32'(i_waitrequest), 32'((k % 2) == 1));
      chk("cont_dw", 32'(d_waitrequest), 32'((k % 2) == 0));
      advance();
    end
    idle(); settle(); chk("cont_count", 32'(pending_count), 32'd2); advance();
    for (int k = 0; k < 2; k++) begin
      h_readdatavalid = 1'b1; h_readdata = 32'h77 + 32'(k); settle();
      chk("cont_rsp_i", 32'(i_readdatavalid), 32'd1);
      advance();
    end

    // Single-requester read with delayed response
    idle(); i_read = 1'b1; i_address = 32'h100; i_byteenable = 4'hF; settle();
    chk("rd_count0", 32'(pending_count), 32'd0);
    chk("rd_haddr", h_address, 32'h100);
    advance();
    idle(); settle(); chk("rd_count1", 32'(pending_count), 32'd1); advance();
    h_readdatavalid = 1'b1; h_readdata = 32'hDEADBEEF; settle();
    chk("rd_irdv", 32'(i_readdatavalid), 32'd1);
    chk("rd_idata", i_readdata, 32'hDEADBEEF);
    chk("rd_drdv", 32'(d_readdatavalid), 32'd0);
    advance();
    idle(); settle(); chk("rd_count2", 32'(pending_count), 32'd0); advance();

    // Lock under host wait: data write holds the grant for 4 cycles
    for (int k = 0; k < 4; k++) begin
      i_read = 1'b1; i_address = 32'h200; i_byteenable = 4'hF;
      d_write = 1'b1; d_address = 32'hA0; d_byteenable = 4'hF; d_writedata = 32'h55;
      h_waitrequest = (k < 3); settle();
      chk("lock_haddr", h_address, 32'hA0);
      chk("lock_hwd", h_writedata, 32'h55);
      chk("lock_iw", 32'(i_waitrequest), 32'd1);
      advance();
    end
    d_write = 1'b0; h_waitrequest = 1'b0; settle();
    chk("lock_next_rd", 32'(h_read), 32'd1);
    chk("lock_next_addr", h_address, 32'h200);
    advance();
    idle(); h_readdatavalid = 1'b1; settle(); advance();

    // FIFO full: 4 reads, then a write passes while the 5th read is held off
    idle();
    for (int k = 0; k < 4; k++) begin
      i_read = 1'b1; i_address = 32'h300 + 32'(4 * k); settle(); advance();
    end
    d_write = 1'b1; d_address = 32'hB0; settle();
    chk("full_write", 32'(h_write), 32'd1);
    chk("full_count", 32'(pending_count), 32'd4);
    advance();
    d_write = 1'b0; settle();
    chk("full_hread", 32'(h_read), 32'd0);
    chk("full_iw", 32'(i_waitrequest), 32'd1);
    chk("full_count2", 32'(pending_count), 32'd4);
    advance();
    h_readdatavalid = 1'b1; settle();
    chk("full_pushpop_rd", 32'(h_read), 32'd1);
    advance();
    i_read = 1'b0; h_readdatavalid = 1'b0; settle();
    chk("full_pushpop_cnt", 32'(pending_count), 32'd4);
    advance();
    for (int k = 0; k < 4; k++) begin h_readdatavalid = 1'b1; settle(); advance(); end

    // Ordering: reads I, D, I then responses A, B, C
    idle(); i_read = 1'b1; i_address = 32'h500; settle(); advance();
    idle(); d_read = 1'b1; d_address = 32'h600; settle(); advance();
    idle(); i_read = 1'b1; i_address = 32'h700; settle(); advance();
    idle();
    for (int k = 0; k < 3; k++) begin
      h_readdatavalid = 1'b1; h_readdata = 32'hA + 32'(k); settle();
      chk("ord_irdv", 32'(i_readdatavalid), 32'(k != 1));
      chk("ord_drdv", 32'(d_readdatavalid), 32'(k == 1));
      advance();
    end

    // Unexpected response, then reset with reads outstanding
    idle(); h_readdatavalid = 1'b1; settle();
    chk("err_irdv", 32'(i_readdatavalid), 32'd0);
    chk("err_drdv", 32'(d_readdatavalid), 32'd0);
    advance();
    idle();
    for (int k = 0; k < 2; k++) begin settle(); chk("err_sticky", 32'(err_unexpected_rdv), 32'd1); advance(); end
    i_read = 1'b1; settle(); advance();
    idle(); d_read = 1'b1; settle(); advance();
    idle(); settle(); chk("pre_rst_count", 32'(pending_count), 32'd2); advance();
    rst = 1'b0; i_read = 1'b1; d_read = 1'b1; h_readdatavalid = 1'b1; settle();
    chk("mid_rst_iw", 32'(i_waitrequest), 32'd1);
    chk("mid_rst_dw", 32'(d_waitrequest), 32'd1);
    chk("mid_rst_count", 32'(pending_count), 32'd0);
    chk("mid_rst_err", 32'(err_unexpected_rdv), 32'd0);
    chk("mid_rst_irdv", 32'(i_readdatavalid), 32'd0);
    advance();
    rst = 1'b1; idle(); h_readdatavalid = 1'b1; settle();
    chk("late_irdv", 32'(i_readdatavalid), 32'd0);
    advance();
    idle(); settle(); chk("late_err", 32'(err_unexpected_rdv), 32'd1); advance();

    // Randomized traffic; requesters hold commands while stalled
    i_hold = 1'b0; d_hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_hold) begin
        i_read = 1'($urandom_range(0, 1)); i_address = $urandom; i_byteenable = 4'($urandom);
      end
      if (!d_hold) begin
        int kind;
        kind = $urandom_range(0, 3);
        d_read = (kind == 1); d_write = (kind == 2);
        d_address = $urandom; d_byteenable = 4'($urandom); d_writedata = $urandom;
      end
      h_waitrequest = ($urandom_range(0, 3) == 0);
      h_readdatavalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      h_readdata = $urandom;
      rst = ($urandom_range(0, 499) != 0);
      settle();
      i_hold = i_read && e_iw;
      d_hold = (d_read || d_write) && e_dw;
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
